// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state type and one-hot helper for the memory port arbiter
package mem_arb_pkg;
  localparam int MAX_REQ = 8;
  localparam int ID_W = 3;
  typedef enum logic {ARB, LOCK} arb_state_e;
  function automatic logic [MAX_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    return MAX_REQ'(1) << id;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: round-robin pick of the first valid requester at or after ptr, with wrap
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    id_o
);
  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0] off;
  logic [ID_W:0] sum;
  assign rot = NUM_REQ'({valid_i, valid_i} >> ptr_i);
  // lowest set bit of the rotated mask is the nearest requester from ptr
  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (rot[i]) off = ID_W'(i);
  end
  assign sum = {1'b0, ptr_i} + {1'b0, off};
  assign id_o = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ)) : sum[ID_W-1:0];
  assign gnt_o = (|valid_i) ? NUM_REQ'(onehot(id_o)) : '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter with bounded lock sharing one single-port SRAM
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int NUM_ENTRIES = 64,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = $clog2(NUM_ENTRIES),
  parameter int MAX_LOCK    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ-1:0]            i_req_we,
  input  logic [NUM_REQ-1:0]            i_req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_mem_cenb,
  output logic                          o_mem_wenb,
  output logic [ADDR_WIDTH-1:0]         o_mem_addr,
  output logic [DATA_WIDTH-1:0]         o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]         i_mem_rdata
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  arb_state_e state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, owner_q, owner_d, rsp_id_q, rsp_id_d, pick_id, gnt_id;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rsp_pend_q, rsp_pend_d;
  logic [ADDR_WIDTH-1:0] addr_q, sel_addr;
  logic [DATA_WIDTH-1:0] wdata_q, sel_wdata;
  logic [NUM_REQ-1:0] pick_gnt, gnt, owner_oh, rsp_oh;
  logic gnt_any, gnt_we, gnt_lock;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid_i(i_req_valid),
    .ptr_i  (ptr_q),
    .gnt_o  (pick_gnt),
    .id_o   (pick_id)
  );

  assign owner_oh = NUM_REQ'(onehot(owner_q));
  assign rsp_oh = NUM_REQ'(onehot(rsp_id_q));
  assign gnt = !rst_n ? '0 : (state_q == LOCK) ? (owner_oh & i_req_valid) : pick_gnt;
  assign gnt_id = (state_q == LOCK) ? owner_q : pick_id;
  assign gnt_any = |gnt;
  assign gnt_we = |(gnt & i_req_we);
  assign gnt_lock = |(gnt & i_req_lock);

  // route the granted command to the macro; idle cycles replay the last address/data
  always_comb begin
    sel_addr = addr_q;
    sel_wdata = wdata_q;
    for (int k = 0; k < NUM_REQ; k++) if (gnt[k]) begin
      sel_addr = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      sel_wdata = i_req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign o_req_ready = gnt;
  assign o_mem_cenb = ~gnt_any;
  assign o_mem_wenb = ~(gnt_any & gnt_we);
  assign o_mem_addr = sel_addr;
  assign o_mem_wdata = sel_wdata;
  assign o_rsp_valid = rsp_oh & {NUM_REQ{rsp_pend_q}};
  assign o_rsp_data = i_mem_rdata;

  // pointer advance, lock entry and lock release (by lock=0 or by reaching MAX_LOCK)
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    cnt_d = cnt_q;
    rsp_pend_d = gnt_any & ~gnt_we;
    rsp_id_d = gnt_id;
    if (gnt_any && state_q == ARB) begin
      ptr_d = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + ID_W'(1);
      if (gnt_lock && MAX_LOCK > 1) begin
        state_d = LOCK;
        owner_d = pick_id;
        cnt_d = CW'(1);
      end
    end else if (gnt_any) begin
      cnt_d = cnt_q + CW'(1);
      if (!gnt_lock || cnt_q == CW'(MAX_LOCK - 1)) begin
        state_d = ARB;
        cnt_d = '0;
      end
    end
  end

  // all arbiter state; reset drops any lock and any pending read response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      ptr_q <= '0;
      owner_q <= '0;
      cnt_q <= '0;
      rsp_pend_q <= 1'b0;
      rsp_id_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      rsp_pend_q <= rsp_pend_d;
      rsp_id_q <= rsp_id_d;
      addr_q <= sel_addr;
      wdata_q <= sel_wdata;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with an SRAM model behind the arbiter
module tb_mem_port_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] valid, we, lock, ready, rsp_valid;
  logic [AW-1:0] a0, a1, maddr;
  logic [DW-1:0] d0, d1, rsp_data, mwdata, mrdata;
  logic cenb, wenb;
  logic [DW-1:0] mem [64];
  logic [DW-1:0] ref_mem [64];
  int checks = 0;
  int errors = 0;
  typedef struct packed {logic [1:0] oh; logic [DW-1:0] data;} exp_t;
  exp_t q[$];

  mem_port_arbiter #(.NUM_REQ(2), .NUM_ENTRIES(64), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LOCK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(valid), .o_req_ready(ready), .i_req_we(we), .i_req_lock(lock),
    .i_req_addr({a1, a0}), .i_req_wdata({d1, d0}),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
    .o_mem_cenb(cenb), .o_mem_wenb(wenb), .o_mem_addr(maddr), .o_mem_wdata(mwdata),
    .i_mem_rdata(mrdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!cenb) begin
    if (!wenb) mem[maddr] <= mwdata;
    else mrdata <= mem[maddr];
  end

  task automatic drive(input logic [1:0] v, w, l, input logic [AW-1:0] x0, x1, input logic [DW-1:0] y0, y1);
    valid = v; we = w; lock = l; a0 = x0; a1 = x1; d0 = y0; d1 = y1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    exp_t e;
    logic [AW-1:0] a;
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
      return;
    end
    checks++;
    if (q.size() != 0) begin
      e = q.pop_front();
      if (rsp_valid !== e.oh || rsp_data !== e.data) begin
        errors++;
        $display("FAIL rsp: got valid=%b data=%h, want valid=%b data=%h", rsp_valid, rsp_data, e.oh, e.data);
      end
    end else if (rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL rsp_idle: got valid=%b, want 00", rsp_valid);
    end
    for (int k = 0; k < 2; k++) if (valid[k] && ready[k]) begin
      a = k ? a1 : a0;
      if (we[k]) ref_mem[a] = k ? d1 : d0;
      else q.push_back('{oh: 2'b01 << k, data: ref_mem[a]});
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    drive(2'b11, 2'b00, 2'b00, 6'd5, 6'd6, 8'h11, 8'h22);
    #2;
    checks++; if (ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp: got %b want 00", rsp_valid); end
    checks++; if (cenb !== 1'b1 || wenb !== 1'b1) begin errors++; $display("FAIL reset_en: got cenb=%b wenb=%b want 1 1", cenb, wenb); end
    checks++; if (maddr !== 6'd0 || mwdata !== 8'h00) begin errors++; $display("FAIL reset_bus: got addr=%0d wdata=%h want 0 00", maddr, mwdata); end
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    drive(2'b01, 2'b01, 2'b00, 6'd5, 6'd0, 8'hA5, 8'h00);
    sample();
    checks++; if (ready !== 2'b01) begin errors++; $display("FAIL sr_wr_ready: got %b want 01", ready); end
    step();
    drive(2'b10, 2'b00, 2'b00, 6'd0, 6'd5, 8'h00, 8'h00);
    sample();
    checks++; if (ready !== 2'b10) begin errors++; $display("FAIL sr_rd_ready: got %b want 10", ready); end
    checks++; if (cenb !== 1'b0 || wenb !== 1'b1 || maddr !== 6'd5) begin errors++; $display("FAIL sr_mem: got cenb=%b wenb=%b addr=%0d want 0 1 5", cenb, wenb, maddr); end
    step();
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    sample();
    checks++; if (rsp_valid !== 2'b10 || rsp_data !== 8'hA5) begin errors++; $display("FAIL sr_rsp: got %b %h want 10 a5", rsp_valid, rsp_data); end
    step();
  endtask

  task automatic test_fairness();
    int c0 = 0;
    int c1 = 0;
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 2'b00, 2'b00, 6'd5, 6'd5, 0, 0);
      sample();
      checks++; if (ready !== ((i % 2) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", i, ready, (i % 2) ? 2'b10 : 2'b01); end
      c0 += int'(ready[0]);
      c1 += int'(ready[1]);
      step();
    end
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    sample();
    step();
    checks++; if (c0 != 4 || c1 != 4) begin errors++; $display("FAIL fair_count: got %0d/%0d want 4/4", c0, c1); end
  endtask

  task automatic test_lock_burst();
    logic [1:0] exp_b [4] = '{2'b01, 2'b01, 2'b10, 2'b01};
    int n0 = 0;
    logic g1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive({1'b1, i < 4}, 2'b01, {1'b0, i < 3}, 6'(10 + i), 6'd5, 8'(8'h10 + i), 8'h00);
      sample();
      checks++; if (ready !== (i < 4 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL lock_burst%0d: got %b want %b", i, ready, i < 4 ? 2'b01 : 2'b10); end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive({!g1, n0 < 3}, 2'b01, {1'b0, n0 == 0}, 6'(30 + n0), 6'd10, 8'(8'h20 + n0), 8'h00);
      sample();
      checks++; if (ready !== exp_b[i]) begin errors++; $display("FAIL lock_release%0d: got %b want %b", i, ready, exp_b[i]); end
      n0 += int'(ready[0]);
      g1 = g1 | ready[1];
      step();
    end
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    sample();
    step();
  endtask

  task automatic test_forced_release();
    logic [1:0] exp_f [13] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
    int n0 = 0;
    reset_dut();
    for (int i = 0; i < 13; i++) begin
      drive({1'b1, n0 < 10}, 2'b01, {1'b0, n0 < 9}, 6'(20 + n0), 6'd5, 8'(8'h40 + n0), 8'h00);
      sample();
      checks++; if (ready !== exp_f[i]) begin errors++; $display("FAIL forced%0d: got %b want %b", i, ready, exp_f[i]); end
      n0 += int'(ready[0]);
      step();
    end
    checks++; if (n0 != 10) begin errors++; $display("FAIL forced_count: got %0d want 10", n0); end
  endtask

  task automatic test_idle_write();
    for (int i = 0; i < 2; i++) begin
      drive(2'b00, 2'b00, 2'b00, 6'd33, 6'd44, 8'h55, 8'h66);
      sample();
      checks++; if (cenb !== 1'b1 || wenb !== 1'b1 || maddr !== 6'd5) begin errors++; $display("FAIL idle%0d: got cenb=%b wenb=%b addr=%0d want 1 1 5", i, cenb, wenb, maddr); end
      step();
    end
    drive(2'b01, 2'b01, 2'b00, 6'd63, 6'd0, 8'h3C, 8'h00);
    sample();
    checks++; if (ready !== 2'b01 || wenb !== 1'b0 || maddr !== 6'd63 || mwdata !== 8'h3C) begin errors++; $display("FAIL wr63: got ready=%b wenb=%b addr=%0d wdata=%h want 01 0 63 3c", ready, wenb, maddr, mwdata); end
    step();
    drive(2'b01, 2'b00, 2'b00, 6'd63, 6'd0, 8'h00, 8'h00);
    sample();
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL wr_no_rsp: got %b want 00", rsp_valid); end
    checks++; if (ready !== 2'b01 || wenb !== 1'b1) begin errors++; $display("FAIL rd63: got ready=%b wenb=%b want 01 1", ready, wenb); end
    step();
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    sample();
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== 8'h3C) begin errors++; $display("FAIL rd63_rsp: got %b %h want 01 3c", rsp_valid, rsp_data); end
    checks++; if (maddr !== 6'd63) begin errors++; $display("FAIL addr_hold: got %0d want 63", maddr); end
    step();
  endtask

  task automatic test_back_to_back();
    drive(2'b11, 2'b10, 2'b00, 6'd9, 6'd9, 8'h00, 8'h77);
    sample();
    checks++; if (ready !== 2'b10) begin errors++; $display("FAIL b2b_wr: got %b want 10", ready); end
    step();
    drive(2'b01, 2'b00, 2'b00, 6'd9, 6'd0, 8'h00, 8'h00);
    sample();
    checks++; if (ready !== 2'b01) begin errors++; $display("FAIL b2b_rd: got %b want 01", ready); end
    step();
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    sample();
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== 8'h77) begin errors++; $display("FAIL b2b_rsp: got %b %h want 01 77", rsp_valid, rsp_data); end
    step();
  endtask

  task automatic test_reset_midop();
    drive(2'b10, 2'b00, 2'b00, 6'd0, 6'd63, 8'h00, 8'h00);
    sample();
    checks++; if (ready !== 2'b10) begin errors++; $display("FAIL mid_grant: got %b want 10", ready); end
    step();
    rst_n = 1'b0;
    drive(2'b11, 2'b00, 2'b00, 6'd7, 6'd8, 8'h99, 8'h88);
    q.delete();
    #1;
    checks++; if (rsp_valid !== 2'b00 || ready !== 2'b00) begin errors++; $display("FAIL mid_rst_out: got rsp=%b ready=%b want 00 00", rsp_valid, ready); end
    checks++; if (cenb !== 1'b1 || wenb !== 1'b1 || maddr !== 6'd0 || mwdata !== 8'h00) begin errors++; $display("FAIL mid_rst_mem: got %b %b %0d %h want 1 1 0 00", cenb, wenb, maddr, mwdata); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    step();
    sample();
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL mid_no_rsp: got %b want 00", rsp_valid); end
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    test_lock_burst();
    test_forced_release();
    test_idle_write();
    test_back_to_back();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
